// File: rtl/arb_mux_ctrl_pkg.sv
// arb_mux_ctrl_pkg: shared state/select encodings and default widths
package arb_mux_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/arb_mux_ctrl_if.sv
// arb_mux_ctrl_if: requester, consumer and status signals of the arbiter
interface arb_mux_ctrl_if import arb_mux_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic req_a;
  logic [WIDTH-1:0] data_a;
  logic gnt_a;
  logic req_b;
  logic [WIDTH-1:0] data_b;
  logic gnt_b;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic out_ready;
  logic sel;
  logic [CNT_W-1:0] xfer_cnt;
  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input gnt_a, gnt_b, out_valid, out_data, sel, xfer_cnt
  );
  modport slave (
    input req_a, data_a, req_b, data_b, out_ready,
    output gnt_a, gnt_b, out_valid, out_data, sel, xfer_cnt
  );
endinterface

// File: rtl/arb_mux_ctrl_mux2_bus.sv
// mux2_bus: combinational WIDTH-wide 2:1 select
module mux2_bus #(
  parameter int WIDTH = 8
) (
  input logic [WIDTH-1:0] a,
  input logic [WIDTH-1:0] b,
  input logic sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/arb_mux_ctrl.sv
// arb_mux_ctrl: round-robin 2:1 arbiter feeding a one-entry output buffer
module arb_mux_ctrl import arb_mux_ctrl_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  arb_mux_ctrl_if.slave bus
);
  logic [0:0] state;
  logic last;
  logic load_ok;
  logic pick_b;
  logic [WIDTH-1:0] mux_y;
  always_comb begin
    load_ok = (state == EMPTY) || bus.out_ready;
    pick_b = bus.req_b && (!bus.req_a || last == SEL_A);
    bus.gnt_a = !rst && load_ok && bus.req_a && !pick_b;
    bus.gnt_b = !rst && load_ok && pick_b;
  end
  assign bus.out_valid = state == FULL;
  mux2_bus #(.WIDTH(WIDTH)) u_mux (.a(bus.data_a), .b(bus.data_b), .sel(pick_b), .y(mux_y));
  // a delivery and a reload may coincide; the reload wins the state update
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      bus.out_data <= '0;
      bus.sel <= SEL_A;
      bus.xfer_cnt <= '0;
      last <= SEL_B;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.xfer_cnt <= bus.xfer_cnt + CNT_W'(1);
      if (bus.gnt_a || bus.gnt_b) begin
        state <= FULL;
        bus.out_data <= mux_y;
        bus.sel <= pick_b;
        last <= pick_b;
      end else if (bus.out_ready) state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_arb_mux_ctrl.sv
// tb_arb_mux_ctrl: directed and random checks against a transaction-level model
module tb_arb_mux_ctrl;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  arb_mux_ctrl_if #(.WIDTH(8), .CNT_W(16)) bus ();
  arb_mux_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus4 ();
  arb_mux_ctrl #(.WIDTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  arb_mux_ctrl #(.WIDTH(8), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  assign bus4.req_a = bus.req_a;
  assign bus4.data_a = bus.data_a;
  assign bus4.req_b = bus.req_b;
  assign bus4.data_b = bus.data_b;
  assign bus4.out_ready = bus.out_ready;
  always #5 clk = ~clk;
  bit m_valid;
  logic [7:0] m_data;
  bit m_sel;
  bit m_last;
  int m_cnt;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_valid = 0;
    m_data = 8'h00;
    m_sel = 0;
    m_last = 1;
    m_cnt = 0;
  endtask
  task automatic cycle(input string tag, input bit r, input bit ra, input logic [7:0] da,
                       input bit rb, input logic [7:0] db, input bit ordy);
    bit lok, win_b, ea, eb;
    rst = r;
    bus.req_a = ra;
    bus.data_a = da;
    bus.req_b = rb;
    bus.data_b = db;
    bus.out_ready = ordy;
    #1;
    lok = !m_valid || ordy;
    win_b = (ra && rb) ? !m_last : rb;
    ea = !r && lok && (ra || rb) && !win_b;
    eb = !r && lok && (ra || rb) && win_b;
    chk({tag, ":gnt_a"}, 32'(bus.gnt_a), 32'(ea));
    chk({tag, ":gnt_b"}, 32'(bus.gnt_b), 32'(eb));
    chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ":out_data"}, 32'(bus.out_data), 32'(m_data));
    chk({tag, ":sel"}, 32'(bus.sel), 32'(m_sel));
    chk({tag, ":xfer_cnt"}, 32'(bus.xfer_cnt), 32'(m_cnt % 65536));
    chk({tag, ":xfer_cnt4"}, 32'(bus4.xfer_cnt), 32'(m_cnt % 16));
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (m_valid && ordy) m_cnt++;
      if (ea || eb) begin
        m_valid = 1;
        m_data = eb ? db : da;
        m_sel = eb;
        m_last = eb;
      end else if (ordy) m_valid = 0;
    end
    #1;
  endtask
  initial begin
    rst = 1;
    bus.req_a = 0;
    bus.data_a = 0;
    bus.req_b = 0;
    bus.data_b = 0;
    bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle("reset", 1, 1, 8'hAA, 1, 8'hBB, 1);
    cycle("single0", 0, 1, 8'h5A, 0, 8'h00, 1);
    chk("single:data", 32'(bus.out_data), 32'h5A);
    cycle("single1", 0, 0, 8'h00, 0, 8'h00, 1);
    chk("single:cnt", 32'(bus.xfer_cnt), 32'd1);
    cycle("rst_f", 1, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      cycle("fair", 0, 1, 8'h11, 1, 8'h22, 1);
      chk("fair:data", 32'(bus.out_data), (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    cycle("bp_load", 0, 1, 8'h33, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      cycle("bp_hold", 0, 0, 8'h00, 1, 8'h44, 0);
      chk("bp:data", 32'(bus.out_data), 32'h33);
    end
    cycle("bp_go", 0, 0, 8'h00, 1, 8'h44, 1);
    chk("bp:next", 32'(bus.out_data), 32'h44);
    cycle("wrap_rst", 1, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 18; i++) cycle("wrap", 0, 1, 8'(i), 0, 8'h00, 1);
    chk("wrap:cnt4", 32'(bus4.xfer_cnt), 32'd1);
    cycle("mid_load", 0, 0, 8'h00, 1, 8'h77, 0);
    cycle("mid_hold", 0, 0, 8'h00, 0, 8'h00, 0);
    cycle("mid_rst", 1, 0, 8'h00, 0, 8'h00, 0);
    chk("mid:valid", 32'(bus.out_valid), 32'd0);
    chk("mid:cnt", 32'(bus.xfer_cnt), 32'd0);
    cycle("mid_tie", 0, 1, 8'h01, 1, 8'h02, 1);
    chk("mid:tie_a", 32'(bus.out_data), 32'h01);
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(0, 49) == 0), 1'($urandom), 8'($urandom),
            1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
